// File: rtl/enemy_sprite_reader_if.sv
// enemy_sprite_reader_if
//   Enemy request bus: per-pixel coordinates plus the is_obj/Obj_address
//   vectors that enemy instances present to the sprite reader.
//   master : producer side (enemy instances / pixel timing)
//   slave  : enemy_sprite_reader
//   Signals:
//     pix_valid        current PixelX/PixelY is a visible pixel
//     PixelX, PixelY   current pixel coordinates (9 bits each)
//     is_obj_vec       bit i = enemy i covers the current pixel
//     Obj_address_vec  enemy i sprite ROM address at [i*ADDR_W +: ADDR_W]
interface enemy_sprite_reader_if #(
    parameter int N_ENEMY = 4,
    parameter int ADDR_W  = 13
);
    logic                        pix_valid;
    logic [8:0]                  PixelX;
    logic [8:0]                  PixelY;
    logic [N_ENEMY-1:0]          is_obj_vec;
    logic [N_ENEMY*ADDR_W-1:0]   Obj_address_vec;

    modport master (
        output pix_valid, PixelX, PixelY, is_obj_vec, Obj_address_vec
    );

    modport slave (
        input  pix_valid, PixelX, PixelY, is_obj_vec, Obj_address_vec
    );
endinterface

// File: rtl/enemy_sprite_reader.sv
// enemy_sprite_reader
//   Arbitrates N_ENEMY sprite requests per pixel (lowest index wins), reads
//   the shared sprite ROM and returns palette index + enemy id aligned with
//   the delayed pixel coordinates. Latency from request to is_enemy/Out_X/
//   Out_Y is 1+ROM_LAT cycles, one pixel per cycle, no stalls. Also counts
//   pixels covered by two or more enemies per frame (saturating at 255).
//   Optional build macro: ENEMY_HITBOX_DEBUG_EN -- transparent hit pixels are
//   shown with DEBUG_COLOR so the whole enemy box becomes visible.
//   Ports:
//     Clk, Reset           clock, synchronous active-high reset
//     frame_clk            frame strobe, rising edge starts a new frame
//     req                  request bus (enemy_sprite_reader_if.slave)
//     rom_addr / rom_data  sprite ROM address (registered) / data
//     is_enemy             opaque enemy pixel at Out_X/Out_Y
//     enemy_color          palette index (0 when is_enemy=0)
//     enemy_id             winning channel (0 when is_enemy=0)
//     Out_X, Out_Y         pixel coordinates aligned with is_enemy
//     overlap_frame        last completed frame had an overlapped pixel
//     overlap_count        overlapped-pixel count of last frame (saturating)
module enemy_sprite_reader #(
    parameter int                  N_ENEMY     = 4,
    parameter int                  ADDR_W      = 13,
    parameter int                  COLOR_W     = 4,
    parameter int                  ROM_LAT     = 1,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = '0,
    parameter logic [COLOR_W-1:0]  DEBUG_COLOR = COLOR_W'(15),
    localparam int                 ID_W        = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    enemy_sprite_reader_if.slave  req,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [COLOR_W-1:0]    rom_data,
    output logic                  is_enemy,
    output logic [COLOR_W-1:0]    enemy_color,
    output logic [ID_W-1:0]       enemy_id,
    output logic [8:0]            Out_X,
    output logic [8:0]            Out_Y,
    output logic                  overlap_frame,
    output logic [7:0]            overlap_count
);

    // one extra bit so the ">=2" threshold is representable even for N_ENEMY=1
    localparam int CNT_W = $clog2(N_ENEMY + 1) + 1;

    // stage 0: arbitration and overlap detection
    logic              w_hit;
    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [ADDR_W-1:0] w_win_addr;
    logic [CNT_W-1:0]  w_pop;
    logic              w_ovl;

    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        w_pop      = '0;
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            w_pop = w_pop + CNT_W'(req.is_obj_vec[i]);
            if (req.is_obj_vec[i] && !w_found) begin
                w_found    = 1'b1;
                w_win      = ID_W'(i);
                w_win_addr = req.Obj_address_vec[i*ADDR_W +: ADDR_W];
            end
        end
        w_hit = req.pix_valid & w_found;
        w_ovl = req.pix_valid & (w_pop >= CNT_W'(2));
    end

    // stage 1 .. ROM_LAT: hit/id/coords travel alongside the ROM read
    logic              r_hit_p [ROM_LAT];
    logic [ID_W-1:0]   r_id_p  [ROM_LAT];
    logic [8:0]        r_x_p   [ROM_LAT];
    logic [8:0]        r_y_p   [ROM_LAT];

    // output stage decode
    logic              w_hit_d;
    logic              w_opaque;
    logic              w_show;
    logic [COLOR_W-1:0] w_fill;

    always_comb begin
        w_hit_d  = r_hit_p[ROM_LAT-1];
        w_opaque = (rom_data != TRANSPARENT);
        w_fill   = w_opaque ? rom_data : DEBUG_COLOR;
`ifdef ENEMY_HITBOX_DEBUG_EN
        w_show   = w_hit_d;
`else
        w_show   = w_hit_d & w_opaque;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr    <= '0;
            is_enemy    <= 1'b0;
            enemy_color <= '0;
            enemy_id    <= '0;
            Out_X       <= '0;
            Out_Y       <= '0;
            for (int unsigned s = 0; s < ROM_LAT; s++) begin
                r_hit_p[s] <= 1'b0;
                r_id_p[s]  <= '0;
                r_x_p[s]   <= '0;
                r_y_p[s]   <= '0;
            end
        end else begin
            // address holds on non-hit cycles; the ROM output is masked by hit anyway
            if (w_hit) begin
                rom_addr <= w_win_addr;
            end
            r_hit_p[0] <= w_hit;
            r_id_p[0]  <= w_win;
            r_x_p[0]   <= req.PixelX;
            r_y_p[0]   <= req.PixelY;
            for (int unsigned s = 1; s < ROM_LAT; s++) begin
                r_hit_p[s] <= r_hit_p[s-1];
                r_id_p[s]  <= r_id_p[s-1];
                r_x_p[s]   <= r_x_p[s-1];
                r_y_p[s]   <= r_y_p[s-1];
            end
            is_enemy    <= w_show;
            enemy_color <= w_show ? w_fill : '0;
            enemy_id    <= w_show ? r_id_p[ROM_LAT-1] : '0;
            Out_X       <= r_x_p[ROM_LAT-1];
            Out_Y       <= r_y_p[ROM_LAT-1];
        end
    end

    // per-frame overlap statistics
    logic       r_fclk_d;
    logic [7:0] r_run_cnt;
    logic       w_frame_edge;

    assign w_frame_edge = frame_clk & ~r_fclk_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fclk_d      <= 1'b0;
            r_run_cnt     <= '0;
            overlap_count <= '0;
            overlap_frame <= 1'b0;
        end else begin
            r_fclk_d <= frame_clk;
            if (w_frame_edge) begin
                overlap_count <= r_run_cnt;
                overlap_frame <= (r_run_cnt != '0);
                // an overlap pixel on the edge cycle belongs to the new frame
                r_run_cnt     <= w_ovl ? 8'd1 : 8'd0;
            end else if (w_ovl && (r_run_cnt != 8'hFF)) begin
                r_run_cnt <= r_run_cnt + 8'd1;
            end
        end
    end

endmodule
